pattern_dump_tx: RTL



---
 rtl/pattern_dump_tx.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/pattern_dump_tx.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pattern_dump_tx                                                 |
// | Purpose  : reads pattern words from BRAM and dumps them as a UART 8N1 frame |
// |            FA, len[15:8], len[7:0], 8 bytes/word MSB-first, [xor], FF       |
// | Option   : PATTERN_DUMP_CHECKSUM_EN adds an XOR-of-data byte before FF      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module pattern_dump_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = 10,
  parameter int RD_LAT       = 1
) (
  input  logic              c_tx,
  input  logic              reset,
  input  logic              start,
  input  logic [15:0]       length,
  input  logic [63:0]       dout,
  output logic [ADDR_W-1:0] ad,
  output logic              rd_en,
  output logic              txd,
  output logic              busy,
  output logic              done
);

  localparam int c_CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_CW-1:0] c_CLK_MAX = c_CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_DATA = 3'd2,
    S_CSUM = 3'd3,
    S_TRL  = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  state_t            w_tail_state;

  logic [9:0]        r_shift;
  logic [c_CW-1:0]   r_clk_cnt;
  logic [3:0]        r_bit_cnt;
  logic [2:0]        r_byte_idx;
  logic [15:0]       r_len;
  logic [16:0]       r_words;
  logic [16:0]       r_issued;
  logic [63:0]       r_next_word;
  logic [63:0]       r_cur_word;
  logic              r_nw_valid;
  logic              r_inflight;
  logic              r_rd_en;
  logic [RD_LAT-1:0] r_rd_pipe;
  logic [ADDR_W-1:0] r_ad;
  logic              r_done;

  logic              w_bit_end;
  logic              w_byte_end;
  logic              w_load;
  logic [7:0]        w_byte;
  logic [7:0]        w_word_byte;
  logic [7:0]        w_tail_byte;
  logic              w_finish;
  logic              w_consume;
  logic              w_issue;

  assign w_bit_end   = (r_clk_cnt == c_CLK_MAX);
  assign w_byte_end  = w_bit_end && (r_bit_cnt == 4'd9);
  assign w_word_byte = r_cur_word[{3'd6 - r_byte_idx, 3'b000} +: 8];

`ifdef PATTERN_DUMP_CHECKSUM_EN
  logic [7:0] r_csum;
  assign w_tail_state = S_CSUM;
  assign w_tail_byte  = r_csum;
`else
  assign w_tail_state = S_TRL;
  assign w_tail_byte  = 8'hFF;
`endif

  always_ff @(posedge c_tx) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Every transition happens on a stop-bit end, loading the next byte at once
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_byte      = 8'hFF;
    w_finish    = 1'b0;
    w_consume   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_HDR;
          w_load      = 1'b1;
          w_byte      = 8'hFA;
        end
      end
      S_HDR: begin
        if (w_byte_end) begin
          w_load = 1'b1;
          if (r_byte_idx == 3'd0) begin
            w_byte = r_len[15:8];
          end else if (r_byte_idx == 3'd1) begin
            w_byte = r_len[7:0];
          end else if (r_len == 16'd0) begin
            w_state_nxt = w_tail_state;
            w_byte      = w_tail_byte;
          end else begin
            w_state_nxt = S_DATA;
            w_byte      = r_next_word[63:56];
            w_consume   = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (w_byte_end) begin
          w_load = 1'b1;
          if (r_byte_idx != 3'd7) begin
            w_byte = w_word_byte;
          end else if (r_words == {1'b0, r_len}) begin
            w_state_nxt = w_tail_state;
            w_byte      = w_tail_byte;
          end else begin
            w_byte    = r_next_word[63:56];
            w_consume = 1'b1;
          end
        end
      end
`ifdef PATTERN_DUMP_CHECKSUM_EN
      S_CSUM: begin
        if (w_byte_end) begin
          w_state_nxt = S_TRL;
          w_load      = 1'b1;
          w_byte      = 8'hFF;
        end
      end
`endif
      S_TRL: begin
        if (w_byte_end) begin
          w_state_nxt = S_IDLE;
          w_finish    = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Serializer: {stop, data, start} shifted out LSB first; ones fill behind
  always_ff @(posedge c_tx) begin
    if (reset) begin
      r_shift   <= 10'h3FF;
      r_clk_cnt <= '0;
      r_bit_cnt <= 4'd0;
    end else if (w_load) begin
      r_shift   <= {1'b1, w_byte, 1'b0};
      r_clk_cnt <= '0;
      r_bit_cnt <= 4'd0;
    end else if (r_state != S_IDLE) begin
      if (w_bit_end) begin
        r_clk_cnt <= '0;
        r_shift   <= {1'b1, r_shift[9:1]};
        r_bit_cnt <= r_bit_cnt + 4'd1;
      end else begin
        r_clk_cnt <= r_clk_cnt + c_CW'(1);
      end
    end
  end

  always_ff @(posedge c_tx) begin
    if (reset) begin
      r_byte_idx <= 3'd0;
      r_len      <= 16'd0;
      r_words    <= 17'd0;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (r_state == S_IDLE && start) begin
        r_len   <= length;
        r_words <= 17'd0;
      end else if (w_consume) begin
        r_words <= r_words + 17'd1;
      end
      if (w_load) begin
        if (w_state_nxt != r_state || r_byte_idx == 3'd7) r_byte_idx <= 3'd0;
        else                                              r_byte_idx <= r_byte_idx + 3'd1;
      end
    end
  end

`ifdef PATTERN_DUMP_CHECKSUM_EN
  always_ff @(posedge c_tx) begin
    if (reset) begin
      r_csum <= 8'h00;
    end else if (r_state == S_IDLE) begin
      r_csum <= 8'h00;
    end else if (w_load && w_state_nxt == S_DATA) begin
      r_csum <= r_csum ^ w_byte;
    end
  end
`endif

  // Prefetch: keep one word staged ahead so each word's first byte never waits
  assign w_issue = (r_state != S_IDLE) && !r_nw_valid && !r_inflight &&
                   (r_issued < {1'b0, r_len});

  always_ff @(posedge c_tx) begin
    if (reset || w_finish || r_state == S_IDLE) begin
      r_rd_en     <= 1'b0;
      r_rd_pipe   <= '0;
      r_ad        <= '0;
      r_issued    <= 17'd0;
      r_nw_valid  <= 1'b0;
      r_inflight  <= 1'b0;
      r_next_word <= 64'd0;
      r_cur_word  <= 64'd0;
    end else begin
      r_rd_en      <= w_issue;
      r_rd_pipe[0] <= r_rd_en;
      for (int i = 1; i < RD_LAT; i++) r_rd_pipe[i] <= r_rd_pipe[i-1];
      if (w_issue) begin
        r_ad       <= r_issued[ADDR_W-1:0];
        r_issued   <= r_issued + 17'd1;
        r_inflight <= 1'b1;
      end
      if (r_rd_pipe[RD_LAT-1]) begin
        r_next_word <= dout;
        r_nw_valid  <= 1'b1;
        r_inflight  <= 1'b0;
      end
      if (w_consume) begin
        r_cur_word <= r_next_word;
        r_nw_valid <= 1'b0;
      end
    end
  end

  assign txd   = r_shift[0];
  assign busy  = (r_state != S_IDLE);
  assign done  = r_done;
  assign ad    = r_ad;
  assign rd_en = r_rd_en;

endmodule
`default_nettype wire
